pixel_fb_writer: RTL and testbench
==================================

Name: pixel_fb_writer

Overview:
Downstream stage of the circle/clear drawing FSM. Consumes its pixel stream (vga_x, vga_y, vga_colour, vga_plot) and converts each plotted pixel into a write to the 160x120, 3-bit frame memory.
- Clips off-screen coordinates, caused by wrapped xc±offset arithmetic upstream.
- Computes the linear address.
- Absorbs frame-memory stalls in a small FIFO, since the upstream FSM cannot be back-pressured.

Parameters:
- FB_W, 160, frame width in pixels
- FB_H, 120, frame height in pixels
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, ≥2
- ADDR_W, 15, frame memory address width; must satisfy FB_W*FB_H ≤ 2^ADDR_W

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  synchronous, active-high reset
- vga_x  in  8  pixel x from drawing FSM
- vga_y  in  7  pixel y from drawing FSM
- vga_colour  in  3  pixel colour
- vga_plot  in  1  pixel valid, sampled every cycle; no handshake back
- mem_ready  in  1  frame memory accepts the write this cycle
- mem_addr  out  ADDR_W  write address, = y*FB_W + x
- mem_wdata  out  3  write colour
- mem_we  out  1  write request, held until accepted
- ovf_clr  in  1  clears sticky overflow flag
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- idle  out  1  pipeline and FIFO empty

Behaviour:
- Reset (rstn=1 at an edge): S1 valid=0, FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, overflow=0, idle=1. Reset mid-operation discards all buffered pixels; no partial write.
- Stage S1: at each edge with vga_plot=1, register x, y and colour, and set s1_valid=1; otherwise s1_valid=0. No pixel is ever skipped at S1.
- Clip, combinational on S1:
  - in_range = (x < FB_W) && (y < FB_H), compared unsigned on full input widths.
  - Out-of-range pixels are silently discarded. They are not pushed and do not set overflow.
- Address, combinational on S1:
  - addr = (y<<7) + (y<<5) + x when FB_W=160; generic y*FB_W + x otherwise.
  - Computed at ADDR_W bits with no truncation. Maximum is 19199.
- Push: an in-range S1 pixel is pushed at the next edge if the FIFO is not full, or if a pop occurs in the same cycle (push and pop are simultaneous on a full FIFO).
  - Otherwise the pixel is dropped and overflow is set to 1.
- FIFO output:
  - mem_we = !empty.
  - mem_addr/mem_wdata = head entry, driven from registers.
  - Pop at the edge where mem_we && mem_ready.
  - mem_addr/mem_wdata stay stable while mem_we=1 and mem_ready=0.
- Latency: a vga_plot sampled at edge k gives mem_we=1 in the cycle following edge k+1 (2 cycles) when the FIFO is empty.
- Throughput: 1 pixel/cycle sustained with mem_ready held at 1.
- overflow:
  - Set has priority over ovf_clr in the same cycle.
  - Cleared only by ovf_clr or reset.
- idle = !s1_valid && empty.
- Pointers: log2(FIFO_DEPTH)+1 bits; MSB distinguishes full from empty, with wrap-around on overflow of the pointers.
- No state machine beyond the FIFO; control is valid/pointer based.

Optional Feature:
- Macro: PIXEL_FB_STATS_EN.
- When defined, add outputs:
  - wr_count[15:0]: pixels accepted by memory.
  - clip_count[15:0]: pixels clipped.
  - drop_count[15:0]: pixels dropped on full FIFO.
- Counter behaviour:
  - Each counter saturates at 16'hFFFF.
  - All counters are zeroed by reset and by ovf_clr.
  - Counter increments use the same events as pop, clip and overflow-set.
- When undefined: ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Package pixel_fb_pkg holds:
  - FB_W_DEF=160, FB_H_DEF=120, COLOUR_W=3, ADDR_W_DEF=15.
  - pixel_t typedef {addr[ADDR_W-1:0], colour[2:0]}.
  - Constant function fb_addr(x,y).
- One sub-module: pixel_fifo, a synchronous FIFO of pixel_t with push/pop/full/empty, registered output.
- Clip, address and overflow logic live in the top module.

Test Plan:
- Single pixel (x=80, y=60, colour=3'b101) with mem_ready=1 → exactly one write: mem_addr=9680, mem_wdata=101, mem_we high 1 cycle, 2 cycles after plot.
- Clipping: plot x=200,y=10, then x=5,y=127, then x=159,y=119 → only one write, addr=19199; overflow stays 0.
- Back-pressure: mem_ready=0, burst of 4 in-range pixels → mem_we high with the first address held stable. Release mem_ready → 4 writes in order, and idle=1 afterwards.
- Overflow: mem_ready=0, burst of 6 pixels with FIFO_DEPTH=4 → 4 written after release, 2 dropped, overflow=1. Assert ovf_clr → overflow=0.
- Full-FIFO simultaneous push/pop: FIFO full, mem_ready=1, continuous plots → no drops and overflow stays 0.
- Reset mid-burst: FIFO holding 3 entries, assert rstn 1 cycle → mem_we=0 the next cycle, idle=1, no stale writes. With PIXEL_FB_STATS_EN, also check wr_count/clip_count/drop_count in the scenarios above.

Source files
------------

// File: rtl/pixel_fb_pkg.sv
// pixel_fb_pkg -- shared types and helpers for the pixel frame-buffer writer.
//   FB_W_DEF / FB_H_DEF : default frame geometry (160 x 120)
//   COLOUR_W            : bits per pixel colour
//   ADDR_W_DEF          : default frame memory address width
//   pixel_t             : one buffered memory write {addr, colour}
//   fb_addr()           : linear address y*fb_w + x
package pixel_fb_pkg;

  localparam int unsigned FB_W_DEF   = 160;
  localparam int unsigned FB_H_DEF   = 120;
  localparam int unsigned COLOUR_W   = 3;
  localparam int unsigned ADDR_W_DEF = 15;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [COLOUR_W-1:0]   colour;
  } pixel_t;

  // 160 = 128 + 32, so the common case needs only two shifts and an add.
  function automatic logic [31:0] fb_addr(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] fb_w);
    if (fb_w == 32'd160) begin
      fb_addr = (y << 7) + (y << 5) + x;
    end else begin
      fb_addr = (y * fb_w) + x;
    end
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo -- small synchronous FIFO for buffered frame memory writes.
//   clk      : system clock
//   rst_i    : synchronous active-high reset (empties FIFO, zeroes storage)
//   push_i   : write data_i (ignored when full unless popping the same cycle)
//   pop_i    : drop the head entry (ignored when empty)
//   data_i   : entry to write
//   data_o   : head entry, read straight from the storage registers
//   full_o   : no free entries
//   empty_o  : no valid entries
module pixel_fifo
  import pixel_fb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = $bits(pixel_t)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Pointer MSB is a lap bit: equal indices with different laps means full.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // On a full FIFO a same-cycle pop frees the slot being written.
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) begin
        mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
      end
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer -- turns the drawing FSM pixel stream into frame memory
// writes: registers each plotted pixel, clips off-screen coordinates,
// computes the linear address and buffers writes against memory stalls.
//   clk        : system clock
//   rstn       : synchronous active-high reset
//   vga_x/y    : pixel coordinates from the drawing FSM
//   vga_colour : pixel colour
//   vga_plot   : pixel valid (no back-pressure to the source)
//   mem_ready  : frame memory takes the write this cycle
//   mem_addr   : write address y*FB_W + x
//   mem_wdata  : write colour
//   mem_we     : write request, held until accepted
//   ovf_clr    : clears the sticky overflow flag (and statistics)
//   overflow   : sticky, a pixel was dropped on a full FIFO
//   idle       : nothing in flight
// Optional macro PIXEL_FB_STATS_EN adds saturating wr_count, clip_count and
// drop_count outputs.
module pixel_fb_writer
  import pixel_fb_pkg::*;
#(
  parameter int unsigned FB_W       = FB_W_DEF,
  parameter int unsigned FB_H       = FB_H_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          vga_x,
  input  logic [6:0]          vga_y,
  input  logic [2:0]          vga_colour,
  input  logic                vga_plot,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [2:0]          mem_wdata,
  output logic                mem_we,
  input  logic                ovf_clr,
  output logic                overflow,
  output logic                idle
`ifdef PIXEL_FB_STATS_EN
  ,
  output logic [15:0]         wr_count,
  output logic [15:0]         clip_count,
  output logic [15:0]         drop_count
`endif
);

  localparam int unsigned PIX_W = ADDR_W + COLOUR_W;

  logic                s1_valid_q, s1_valid_d;
  logic [7:0]          s1_x_q, s1_x_d;
  logic [6:0]          s1_y_q, s1_y_d;
  logic [2:0]          s1_colour_q, s1_colour_d;
  logic                overflow_q, overflow_d;

  logic                in_range;
  logic [ADDR_W-1:0]   s1_addr;
  logic                fifo_full, fifo_empty;
  logic                push, pop, ovf_set, clip;
  logic [PIX_W-1:0]    push_data, head_data;

  always_comb begin
    s1_valid_d  = vga_plot;
    s1_x_d      = vga_x;
    s1_y_d      = vga_y;
    s1_colour_d = vga_colour;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_colour_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_colour_q <= s1_colour_d;
      overflow_q  <= overflow_d;
    end
  end

  // Wrapped xc-offset arithmetic upstream shows up here as large x or y.
  assign in_range = (32'(s1_x_q) < FB_W) && (32'(s1_y_q) < FB_H);
  assign s1_addr  = ADDR_W'(fb_addr(32'(s1_x_q), 32'(s1_y_q), FB_W));

  assign pop       = !fifo_empty && mem_ready;
  assign clip      = s1_valid_q && !in_range;
  assign push      = s1_valid_q && in_range && (!fifo_full || pop);
  assign ovf_set   = s1_valid_q && in_range && fifo_full && !pop;
  assign push_data = {s1_addr, s1_colour_q};

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  pixel_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_we    = !fifo_empty;
  assign mem_addr  = head_data[PIX_W-1:COLOUR_W];
  assign mem_wdata = head_data[COLOUR_W-1:0];
  assign overflow  = overflow_q;
  assign idle      = !s1_valid_q && fifo_empty;

`ifdef PIXEL_FB_STATS_EN
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] clip_count_q, clip_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    wr_count_d   = wr_count_q;
    clip_count_d = clip_count_q;
    drop_count_d = drop_count_q;
    if (ovf_clr) begin
      wr_count_d   = '0;
      clip_count_d = '0;
      drop_count_d = '0;
    end else begin
      if (pop && (wr_count_q != 16'hFFFF)) begin
        wr_count_d = wr_count_q + 16'd1;
      end
      if (clip && (clip_count_q != 16'hFFFF)) begin
        clip_count_d = clip_count_q + 16'd1;
      end
      if (ovf_set && (drop_count_q != 16'hFFFF)) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_count_q   <= '0;
      clip_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      wr_count_q   <= wr_count_d;
      clip_count_q <= clip_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign wr_count   = wr_count_q;
  assign clip_count = clip_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_pixel_fb_writer.sv
module tb_pixel_fb_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        mem_ready;
  logic        ovf_clr;
  logic [14:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_we;
  logic        overflow;
  logic        idle;
`ifdef PIXEL_FB_STATS_EN
  logic [15:0] wr_count, clip_count, drop_count;
`endif

  always #5 clk = ~clk;

  pixel_fb_writer #(
    .FB_W(160), .FB_H(120), .FIFO_DEPTH(DEPTH), .ADDR_W(15)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow),
    .idle       (idle)
`ifdef PIXEL_FB_STATS_EN
    ,
    .wr_count   (wr_count),
    .clip_count (clip_count),
    .drop_count (drop_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a pending pixel plus a bounded queue of writes,
  // each entry stored as addr*8 + colour.
  bit m_s1_v;
  int m_s1_x, m_s1_y, m_s1_c;
  int m_q[$];
  bit m_ovf;
  int m_wr, m_clip, m_drop;

  task automatic tick();
    bit pop, inr, push, drop;
    @(posedge clk);
    if (rstn) begin
      m_s1_v = 0; m_q.delete(); m_ovf = 0;
      m_wr = 0; m_clip = 0; m_drop = 0;
    end else begin
      pop  = (m_q.size() > 0) && mem_ready;
      inr  = (m_s1_x < 160) && (m_s1_y < 120);
      push = m_s1_v && inr && ((m_q.size() < DEPTH) || pop);
      drop = m_s1_v && inr && !push;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back((m_s1_y * 160 + m_s1_x) * 8 + m_s1_c);
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (ovf_clr) begin
        m_wr = 0; m_clip = 0; m_drop = 0;
      end else begin
        if (pop && m_wr < 65535) m_wr++;
        if (m_s1_v && !inr && m_clip < 65535) m_clip++;
        if (drop && m_drop < 65535) m_drop++;
      end
      m_s1_v = vga_plot; m_s1_x = vga_x; m_s1_y = vga_y; m_s1_c = vga_colour;
    end
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input int c);
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1; vga_plot = 0; vga_x = 0; vga_y = 0; vga_colour = 0;
    mem_ready = 0; ovf_clr = 0;
    tick(); tick();
    rstn = 0;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 15'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    vectors++; if (mem_wdata !== 3'd0) begin miscompares++; $display("FAIL reset_wdata: got %0d want 0", mem_wdata); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", idle); end
  endtask

  task automatic test_single();
    mem_ready = 1;
    set_pix(80, 60, 5);
    tick();
    vga_plot = 0;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL single_early_we: got %b want 0", mem_we); end
    tick();
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL single_we: got %b want 1", mem_we); end
    vectors++; if (mem_addr !== 15'd9680) begin miscompares++; $display("FAIL single_addr: got %0d want 9680", mem_addr); end
    vectors++; if (mem_wdata !== 3'b101) begin miscompares++; $display("FAIL single_wdata: got %b want 101", mem_wdata); end
    tick();
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL single_we_drop: got %b want 0", mem_we); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_clip();
    int writes = 0;
    int last_addr = -1;
    mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: set_pix(200, 10, 1);
        1: set_pix(5, 127, 2);
        2: set_pix(159, 119, 6);
        default: vga_plot = 0;
      endcase
      tick();
      if (mem_we === 1'b1) begin writes++; last_addr = int'(mem_addr); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clip_ovf: got %b want 0", overflow); end
    end
    vectors++; if (writes != 1) begin miscompares++; $display("FAIL clip_writes: got %0d want 1", writes); end
    vectors++; if (last_addr != 19199) begin miscompares++; $display("FAIL clip_addr: got %0d want 19199", last_addr); end
  endtask

  task automatic test_backpressure();
    int ea[4];
    int ec[4];
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      vga_x = 8'($urandom_range(0, 159)); vga_y = 7'($urandom_range(0, 119));
      vga_colour = 3'($urandom); vga_plot = 1;
      ea[i] = int'(vga_y) * 160 + int'(vga_x); ec[i] = int'(vga_colour);
      tick();
    end
    vga_plot = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (mem_we !== 1'b1 || int'(mem_addr) != ea[0]) begin
        miscompares++; $display("FAIL bp_hold: got we=%b addr=%0d want we=1 addr=%0d", mem_we, mem_addr, ea[0]);
      end
    end
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (mem_we !== 1'b1 || int'(mem_addr) != ea[i] || int'(mem_wdata) != ec[i]) begin
        miscompares++;
        $display("FAIL bp_order%0d: got we=%b addr=%0d data=%0d want 1/%0d/%0d", i, mem_we, mem_addr, mem_wdata, ea[i], ec[i]);
      end
      tick();
    end
    vectors++; if (mem_we !== 1'b0 || idle !== 1'b1) begin
      miscompares++; $display("FAIL bp_idle: got we=%b idle=%b want 0/1", mem_we, idle);
    end
  endtask

  task automatic test_overflow();
    int ea[6];
    int writes = 0;
    ovf_clr = 1; tick(); ovf_clr = 0;
    mem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      set_pix(10 + i, 20 + i, i);
      ea[i] = (20 + i) * 160 + 10 + i;
      tick();
    end
    vga_plot = 0;
    tick();
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", overflow); end
    vectors++; if (int'(mem_addr) != ea[0]) begin miscompares++; $display("FAIL ovf_head: got %0d want %0d", mem_addr, ea[0]); end
    mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (mem_we === 1'b1) begin
        vectors++; if (writes < 4 && int'(mem_addr) != ea[writes]) begin
          miscompares++; $display("FAIL ovf_order: got %0d want %0d", mem_addr, ea[writes]);
        end
        writes++;
      end
      tick();
    end
    vectors++; if (writes != 4) begin miscompares++; $display("FAIL ovf_writes: got %0d want 4", writes); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
`ifdef PIXEL_FB_STATS_EN
    vectors++; if (drop_count !== 16'd2) begin miscompares++; $display("FAIL ovf_dropcnt: got %0d want 2", drop_count); end
    vectors++; if (wr_count !== 16'd4) begin miscompares++; $display("FAIL ovf_wrcnt: got %0d want 4", wr_count); end
`endif
    ovf_clr = 1; tick(); ovf_clr = 0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b want 0", overflow); end
  endtask

  task automatic test_full_pushpop();
    int plotted = 0;
    int writes = 0;
    int after = 0;
    mem_ready = 0;
    while (after < 20) begin
      set_pix($urandom_range(0, 159), $urandom_range(0, 119), $urandom);
      plotted++;
      if (mem_we === 1'b1 && mem_ready) writes++;
      tick();
      if (mem_ready) after++;
      if (m_q.size() == DEPTH) mem_ready = 1;
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_ovf: got %b want 0", overflow); end
      if (plotted > 60) break;
    end
    vga_plot = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_we === 1'b1) writes++;
      tick();
    end
    vectors++; if (writes != plotted) begin miscompares++; $display("FAIL full_count: got %0d want %0d", writes, plotted); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_ovf_end: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_pix(30 + i, 40, 7);
      tick();
    end
    vga_plot = 0;
    tick();
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: got %b want 1", mem_we); end
    rstn = 1; tick(); rstn = 0;
    vectors++; if (mem_we !== 1'b0 || idle !== 1'b1 || mem_addr !== 15'd0) begin
      miscompares++; $display("FAIL rmid_post: got we=%b idle=%b addr=%0d want 0/1/0", mem_we, idle, mem_addr);
    end
    mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rmid_stale: got %b want 0", mem_we); end
    end
  endtask

  task automatic test_random();
    int stall = 0;
    bit exp_we;
    for (int cyc = 0; cyc < 800; cyc++) begin
      vga_plot   = ($urandom_range(0, 3) != 0);
      vga_x      = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
      vga_y      = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 119));
      vga_colour = 3'($urandom);
      if (stall > 0) stall--;
      else if ($urandom_range(0, 15) == 0) stall = $urandom_range(2, 10);
      mem_ready  = (stall == 0) && ($urandom_range(0, 3) != 0);
      ovf_clr    = ($urandom_range(0, 49) == 0);
      tick();
      exp_we = (m_q.size() > 0);
      vectors++; if (mem_we !== exp_we) begin miscompares++; $display("FAIL rnd_we@%0d: got %b want %b", cyc, mem_we, exp_we); end
      if (exp_we) begin
        vectors++; if (int'(mem_addr) != m_q[0] / 8 || int'(mem_wdata) != m_q[0] % 8) begin
          miscompares++;
          $display("FAIL rnd_head@%0d: got %0d/%0d want %0d/%0d", cyc, mem_addr, mem_wdata, m_q[0] / 8, m_q[0] % 8);
        end
      end
      vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf@%0d: got %b want %b", cyc, overflow, m_ovf); end
      vectors++; if (idle !== (!m_s1_v && m_q.size() == 0)) begin
        miscompares++; $display("FAIL rnd_idle@%0d: got %b", cyc, idle);
      end
`ifdef PIXEL_FB_STATS_EN
      vectors++; if (int'(wr_count) != m_wr || int'(clip_count) != m_clip || int'(drop_count) != m_drop) begin
        miscompares++;
        $display("FAIL rnd_stats@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", cyc, wr_count, clip_count, drop_count, m_wr, m_clip, m_drop);
      end
`endif
    end
    ovf_clr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_clip();
    test_backpressure();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
